// File: rtl/dec_input_if.sv
// Processor handshake, switch/button inputs and entry outputs of dec_input.
interface dec_input_if;
  logic        rd_req;
  logic        rd_ack;
  logic [3:0]  digit_sw;
  logic        btn_digit;
  logic        btn_clear;
  logic        btn_enter;
  logic [31:0] entrada;
  logic        valid;
  logic        busy;
  logic [31:0] echo;
  logic [3:0]  digit_cnt;

  modport slave (
    input  rd_req, rd_ack, digit_sw, btn_digit, btn_clear, btn_enter,
    output entrada, valid, busy, echo, digit_cnt
  );

  modport master (
    output rd_req, rd_ack, digit_sw, btn_digit, btn_clear, btn_enter,
    input  entrada, valid, busy, echo, digit_cnt
  );
endinterface

// File: rtl/dec_input.sv
// Decimal keypad entry: buttons -> sync -> (debounce) -> edge, BCD accumulator, processor handshake.
// Define DEC_INPUT_DEBOUNCE_EN to include the button debouncer; all state updates on falling sys_clock.
module dec_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MAX_DIGITS      = 8
) (
  input  logic        sys_clock,
  input  logic        reset,
  dec_input_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_VALID} state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

  // Button vector order: [2]=enter, [1]=clear, [0]=digit
  logic [2:0] s1_q, s1_d, s2_q, s2_d;
  logic [2:0] prev_q, prev_d, armed_q, armed_d;
  logic [1:0] fill_q, fill_d;
  logic [2:0] lvl, evt;

  always_comb begin
    s1_d    = {bus.btn_enter, bus.btn_clear, bus.btn_digit};
    s2_d    = s1_q;
    prev_d  = lvl;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    // A button only arms once it is seen released after the synchronizer has refilled,
    // so a press held through reset produces no event.
    armed_d = armed_q | ({3{fill_q == 2'd2}} & ~s2_q);
    evt     = lvl & ~prev_q & armed_q;
  end

  always_ff @(negedge sys_clock or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      fill_q  <= fill_d;
    end
  end

`ifdef DEC_INPUT_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]         db_lvl_q, db_lvl_d;

  always_comb begin
    db_cnt_d = db_cnt_q;
    db_lvl_d = db_lvl_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (s2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_d[i] = s2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(negedge sys_clock or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      db_lvl_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign lvl = db_lvl_q;
`else
  assign lvl = s2_q;
`endif

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, entrada_q, entrada_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    entrada_d = entrada_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_req) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (evt[2]) begin
          entrada_d = acc_q;
          valid_d   = 1'b1;
          state_d   = S_VALID;
        end else if (evt[1]) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (evt[0] && (bus.digit_sw <= 4'd9) && (cnt_q < MAX_D)) begin
          acc_d = acc_q * 32'd10 + {28'd0, bus.digit_sw};
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_VALID: begin
        if (bus.rd_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ENTRY);
  end

  always_ff @(negedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      entrada_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      entrada_q <= entrada_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.entrada   = entrada_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.echo      = acc_q;
  assign bus.digit_cnt = cnt_q;

endmodule

// File: tb/tb_dec_input.sv
// Self-checking bench for dec_input with a queue scoreboard of committed values.
module tb_dec_input;

  localparam int DB = 16;

  logic sys_clock = 1'b0;
  logic reset     = 1'b1;
  int   checks    = 0;
  int   failures  = 0;
  logic [31:0] sb[$];

  dec_input_if bus ();

  dec_input #(.DEBOUNCE_CYCLES(DB), .MAX_DIGITS(8)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clock);
  endtask

  task automatic press(input logic [2:0] which, input logic [3:0] d);
    bus.digit_sw = d;
    @(posedge sys_clock);
    {bus.btn_enter, bus.btn_clear, bus.btn_digit} = which;
    cyc(DB + 8);
    {bus.btn_enter, bus.btn_clear, bus.btn_digit} = 3'b000;
    cyc(DB + 8);
  endtask

  task automatic pulse_req();
    @(posedge sys_clock); bus.rd_req = 1'b1;
    @(posedge sys_clock); bus.rd_req = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_ack();
    @(posedge sys_clock); bus.rd_ack = 1'b1;
    @(posedge sys_clock); bus.rd_ack = 1'b0;
    cyc(1);
  endtask

  task automatic wait_valid(input string name);
    logic [31:0] exp;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sys_clock);
      if (bus.valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s valid_timeout got=%b want=1", name, bus.valid);
    end else if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty entrada=%0d", name, bus.entrada);
    end else begin
      exp = sb.pop_front();
      if (bus.entrada !== exp) begin
        failures++;
        $display("FAIL %s entrada got=%0d want=%0d", name, bus.entrada, exp);
      end
    end
  endtask

  task automatic commit(input string name, input logic [31:0] exp);
    sb.push_back(exp);
    press(3'b100, 4'd0);
    wait_valid(name);
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if ({bus.entrada, bus.valid, bus.busy, bus.echo, bus.digit_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got entrada=%0d valid=%b busy=%b echo=%0d cnt=%0d want all 0",
               bus.entrada, bus.valid, bus.busy, bus.echo, bus.digit_cnt);
    end
    @(posedge sys_clock); reset = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic();
    pulse_req();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
    press(3'b001, 4'd1);
    press(3'b001, 4'd2);
    press(3'b001, 4'd3);
    checks++;
    if (bus.echo !== 32'd123 || bus.digit_cnt !== 4'd3) begin
      failures++;
      $display("FAIL basic_echo got=%0d/%0d want=123/3", bus.echo, bus.digit_cnt);
    end
    commit("basic", 32'd123);
    cyc(10);
    checks++;
    if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.entrada !== 32'd123) begin
      failures++;
      $display("FAIL basic_hold got valid=%b busy=%b entrada=%0d want 1/0/123", bus.valid, bus.busy, bus.entrada);
    end
    pulse_ack();
    checks++;
    if (bus.valid !== 1'b0 || bus.entrada !== 32'd123) begin
      failures++;
      $display("FAIL basic_ack got valid=%b entrada=%0d want 0/123", bus.valid, bus.entrada);
    end
  endtask

  task automatic test_max_digits();
    pulse_req();
    for (int i = 0; i < 9; i++) press(3'b001, 4'd9);
    checks++;
    if (bus.digit_cnt !== 4'd8 || bus.echo !== 32'd99999999) begin
      failures++;
      $display("FAIL max_digits got cnt=%0d echo=%0d want 8/99999999", bus.digit_cnt, bus.echo);
    end
    commit("max_digits", 32'd99999999);
    pulse_ack();
  endtask

  task automatic test_invalid_digit();
    pulse_req();
    press(3'b001, 4'hC);
    checks++;
    if (bus.echo !== 32'd0 || bus.digit_cnt !== 4'd0) begin
      failures++;
      $display("FAIL invalid_digit got echo=%0d cnt=%0d want 0/0", bus.echo, bus.digit_cnt);
    end
    press(3'b001, 4'd5);
    commit("invalid_digit", 32'd5);
    pulse_ack();
  endtask

`ifdef DEC_INPUT_DEBOUNCE_EN
  task automatic test_debounce();
    pulse_req();
    bus.digit_sw = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clock); bus.btn_digit = 1'b1; cyc(10);
      bus.btn_digit = 1'b0; cyc(10);
    end
    bus.btn_digit = 1'b1; cyc(20);
    bus.btn_digit = 1'b0; cyc(30);
    checks++;
    if (bus.digit_cnt !== 4'd1 || bus.echo !== 32'd6) begin
      failures++;
      $display("FAIL debounce got cnt=%0d echo=%0d want 1/6", bus.digit_cnt, bus.echo);
    end
    commit("debounce", 32'd6);
    pulse_ack();
  endtask
`else
  task automatic test_debounce();
    pulse_req();
    bus.digit_sw = 4'd6;
    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clock); bus.btn_digit = 1'b1; cyc(3);
      bus.btn_digit = 1'b0; cyc(3);
    end
    cyc(4);
    checks++;
    if (bus.digit_cnt !== 4'd2 || bus.echo !== 32'd66) begin
      failures++;
      $display("FAIL sync_edge got cnt=%0d echo=%0d want 2/66", bus.digit_cnt, bus.echo);
    end
    commit("sync_edge", 32'd66);
    pulse_ack();
  endtask
`endif

  task automatic test_priority();
    pulse_req();
    press(3'b001, 4'd7);
    press(3'b001, 4'd8);
    sb.push_back(32'd78);
    press(3'b110, 4'd0);
    wait_valid("priority");
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    pulse_req();
    press(3'b001, 4'd7);
    press(3'b001, 4'd8);
    @(posedge sys_clock); #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.echo !== 32'd0 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.digit_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid got echo=%0d busy=%b valid=%b cnt=%0d want 0/0/0/0",
               bus.echo, bus.busy, bus.valid, bus.digit_cnt);
    end
    bus.btn_digit = 1'b1;
    bus.digit_sw  = 4'd3;
    cyc(3);
    @(posedge sys_clock); reset = 1'b0; bus.rd_req = 1'b1;
    @(posedge sys_clock); bus.rd_req = 1'b0;
    cyc(3 * DB);
    checks++;
    if (bus.busy !== 1'b1 || bus.digit_cnt !== 4'd0) begin
      failures++;
      $display("FAIL held_through_reset got busy=%b cnt=%0d want 1/0", bus.busy, bus.digit_cnt);
    end
    bus.btn_digit = 1'b0;
    cyc(DB + 8);
    press(3'b001, 4'd3);
    checks++;
    if (bus.digit_cnt !== 4'd1 || bus.echo !== 32'd3) begin
      failures++;
      $display("FAIL repress_after_reset got cnt=%0d echo=%0d want 1/3", bus.digit_cnt, bus.echo);
    end
    commit("reset_mid", 32'd3);
    pulse_ack();
  endtask

  task automatic test_ignore();
    press(3'b001, 4'd9);
    checks++;
    if (bus.echo !== 32'd3 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore got echo=%0d busy=%b valid=%b want 3/0/0", bus.echo, bus.busy, bus.valid);
    end
    pulse_req();
    pulse_ack();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL ack_in_entry got busy=%b want=1", bus.busy); end
    press(3'b001, 4'd4);
    commit("ignore", 32'd4);
    press(3'b001, 4'd2);
    pulse_req();
    checks++;
    if (bus.echo !== 32'd4 || bus.entrada !== 32'd4 || bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL valid_ignore got echo=%0d entrada=%0d valid=%b busy=%b want 4/4/1/0",
               bus.echo, bus.entrada, bus.valid, bus.busy);
    end
    pulse_ack();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    bus.rd_req = 1'b0; bus.rd_ack = 1'b0; bus.digit_sw = 4'd0;
    bus.btn_digit = 1'b0; bus.btn_clear = 1'b0; bus.btn_enter = 1'b0;
    test_reset();
    test_basic();
    test_max_digits();
    test_invalid_digit();
    test_debounce();
    test_priority();
    test_reset_mid();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_input.md
DEC_INPUT -- requirements
Module: dec_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter MAX_DIGITS, default 8: maximum decimal digits accepted per entry.
REQ-003 SHALL have port sys_clock, input, 1: sole clock; all state updates on its falling edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port rd_req, input, 1: processor input request; one-cycle pulse.
REQ-006 SHALL have port rd_ack, input, 1: processor has consumed entrada.
REQ-007 SHALL have port digit_sw, input, 4: BCD digit from switches.
REQ-008 SHALL have port btn_digit, input, 1: raw, asynchronous, active-high append-digit button.
REQ-009 SHALL have port btn_clear, input, 1: raw, asynchronous, active-high clear-entry button.
REQ-010 SHALL have port btn_enter, input, 1: raw, asynchronous, active-high commit button.
REQ-011 SHALL have port entrada, output, 32: committed binary value.
REQ-012 SHALL have port valid, output, 1: entrada holds an unconsumed value.
REQ-013 SHALL have port busy, output, 1: entry in progress (ENTRY state).
REQ-014 SHALL have port echo, output, 32: live accumulator, for the decimal display path.
REQ-015 SHALL have port digit_cnt, output, 4: digits accepted in the current entry.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer, then a debouncer, then a rising-edge detector; each press yields exactly one 1-cycle event.
REQ-017 SHALL change a debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any bounce.
REQ-018 SHALL implement states IDLE, ENTRY, VALID; reset state IDLE.
REQ-019 IDLE: on rd_req, clear accumulator and digit_cnt and enter ENTRY next cycle; all button events ignored.
REQ-020 ENTRY, digit event: if digit_sw<=9 and digit_cnt<MAX_DIGITS, accumulator <= accumulator*10 + digit_sw (32-bit) and digit_cnt++; otherwise ignore.
REQ-021 ENTRY, clear event: accumulator and digit_cnt <= 0.
REQ-022 ENTRY, enter event: entrada <= accumulator, valid <= 1, go to VALID; enter with digit_cnt=0 commits 0.
REQ-023 Simultaneous events in one cycle: priority enter > clear > digit; lower-priority events that cycle are discarded.
REQ-024 VALID: hold entrada and valid stable; on rd_ack, valid <= 0 and go to IDLE next cycle; entrada retains its value.
REQ-025 SHALL ignore rd_req in ENTRY and VALID, and rd_ack outside VALID.
REQ-026 busy SHALL be 1 exactly while in ENTRY; echo SHALL equal the accumulator in every state.
REQ-027 MAX_DIGITS=8 SHALL bound echo at 99999999; the accumulator never wraps.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, entrada=0, valid=0, busy=0, echo=0, digit_cnt=0, and clear synchronizers, debouncer counters and debounced levels to 0.
REQ-029 Reset mid-entry SHALL discard the partial value; a button held through reset release SHALL NOT create an event until released and pressed again.

Configuration
REQ-030 With macro DEC_INPUT_DEBOUNCE_EN defined, the REQ-017 debouncer SHALL be included.
REQ-031 Without DEC_INPUT_DEBOUNCE_EN, the debouncer SHALL be omitted, and the synchronized level SHALL feed the edge detector directly (one event per synchronized rising edge).

Verification
REQ-032 rd_req; press digits 1,2,3 then enter; rd_ack -> entrada=123, valid=1 until ack, then IDLE.
REQ-033 ENTRY; press 9 nine times, then enter -> digit_cnt=8, entrada=99999999; the 9th press is ignored.
REQ-034 ENTRY; digit_sw=4'hC, press digit -> echo and digit_cnt unchanged; then 5, enter -> entrada=5.
REQ-035 btn_digit toggled with 10-cycle glitches (DEBOUNCE_CYCLES=16, macro defined) then held 20 cycles -> exactly one digit accepted.
REQ-036 Entered 7,8, then clear and enter debounced in the same cycle -> entrada=78, clear ignored; separately, reset after 7,8 -> echo=0, IDLE, valid=0.
REQ-037 Press digits in IDLE and in VALID -> no change to echo/entrada; rd_req in VALID -> ignored.
